// File: rtl/mips_multicycle_control_if.sv
// Control bundle between the multicycle MIPS main FSM (master) and the datapath (slave).
interface mips_multicycle_control_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic [1:0]       alu_op;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       pc_src;
    logic             pc_en;
    logic             i_or_d;
    logic             ir_write;
    logic             mem_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             reg_write;
    logic             illegal_op;
    logic [3:0]       state;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  opcode, zero, mem_ready,
        output alu_op, alu_src_a, alu_src_b, pc_src, pc_en, i_or_d, ir_write,
               mem_write, reg_dst, mem_to_reg, reg_write, illegal_op, state, instr_count
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  alu_op, alu_src_a, alu_src_b, pc_src, pc_en, i_or_d, ir_write,
               mem_write, reg_dst, mem_to_reg, reg_write, illegal_op, state, instr_count
    );
endinterface

// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath (lw, sw, R-type, beq, addi, j).
// Moore outputs are registered alongside the state; only mem_ready/zero/rst gating is combinational.
module mips_multicycle_control #(
    parameter int MEM_HANDSHAKE = 1,
    parameter int CNT_W         = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    mips_multicycle_control_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       pc_en;
        logic       i_or_d;
        logic       mem_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       fetch;
        logic       branch;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t           state_r;
    state_t           nxt;
    ctrl_t            ctrl_r;
    logic             illegal_r;
    logic [CNT_W-1:0] instr_count_r;
    logic             ready;
    logic             commit;

    function automatic logic is_legal(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

    function automatic ctrl_t moore(input state_t st);
        ctrl_t c;
        c = '0;
        case (st)
            S_FETCH:    begin c.alu_src_b = 2'b01; c.fetch = 1'b1; end
            S_DECODE:   c.alu_src_b = 2'b11;
            S_MEMADR:   begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            S_MEMREAD:  c.i_or_d = 1'b1;
            S_MEMWB:    begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
            S_MEMWRITE: begin c.i_or_d = 1'b1; c.mem_write = 1'b1; end
            S_EXECUTE:  begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
            S_ALUWB:    begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
            S_BRANCH:   begin c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_src = 2'b01; c.branch = 1'b1; end
            S_ADDIEXEC: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            S_ADDIWB:   c.reg_write = 1'b1;
            S_JUMP:     begin c.pc_src = 2'b10; c.pc_en = 1'b1; end
            default:    c = '0;
        endcase
        return c;
    endfunction

    function automatic state_t next_state(input state_t st, input logic [5:0] op, input logic rdy);
        state_t n;
        n = S_FETCH;
        case (st)
            S_FETCH:    n = rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (op == OP_LW || op == OP_SW) n = S_MEMADR;
                else if (op == OP_RTYPE)        n = S_EXECUTE;
                else if (op == OP_BEQ)          n = S_BRANCH;
                else if (op == OP_ADDI)         n = S_ADDIEXEC;
                else if (op == OP_J)            n = S_JUMP;
                else                            n = S_FETCH;
            end
            S_MEMADR:   n = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  n = rdy ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: n = rdy ? S_FETCH : S_MEMWRITE;
            S_EXECUTE:  n = S_ALUWB;
            S_ADDIEXEC: n = S_ADDIWB;
            default:    n = S_FETCH;
        endcase
        return n;
    endfunction

    assign ready  = (MEM_HANDSHAKE != 0) ? bus.mem_ready : 1'b1;
    assign nxt    = next_state(state_r, bus.opcode, ready);
    // Instructions that finish by returning to FETCH; illegal opcodes never reach these states.
    assign commit = (state_r == S_MEMWB) || (state_r == S_ALUWB) || (state_r == S_BRANCH) ||
                    (state_r == S_ADDIWB) || (state_r == S_JUMP) ||
                    ((state_r == S_MEMWRITE) && ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= S_FETCH;
            ctrl_r        <= moore(S_FETCH);
            illegal_r     <= 1'b0;
            instr_count_r <= '0;
        end else begin
            state_r   <= nxt;
            ctrl_r    <= moore(nxt);
            illegal_r <= (state_r == S_DECODE) && !is_legal(bus.opcode);
            if (commit) instr_count_r <= instr_count_r + CNT_W'(1);
        end
    end

    assign bus.alu_op      = ctrl_r.alu_op;
    assign bus.alu_src_a   = ctrl_r.alu_src_a;
    assign bus.alu_src_b   = ctrl_r.alu_src_b;
    assign bus.pc_src      = ctrl_r.pc_src;
    assign bus.i_or_d      = ctrl_r.i_or_d;
    assign bus.reg_dst     = ctrl_r.reg_dst;
    assign bus.mem_to_reg  = ctrl_r.mem_to_reg;
    // Write/load enables are suppressed while reset is held so an aborted access never commits.
    assign bus.pc_en       = !rst && (ctrl_r.pc_en || (ctrl_r.fetch && ready) || (ctrl_r.branch && bus.zero));
    assign bus.ir_write    = !rst && ctrl_r.fetch && ready;
    assign bus.mem_write   = !rst && ctrl_r.mem_write;
    assign bus.reg_write   = !rst && ctrl_r.reg_write;
    assign bus.illegal_op  = illegal_r;
    assign bus.state       = state_r;
    assign bus.instr_count = instr_count_r;
endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: per-instruction cycle sequences built from the instruction timing rules.
module tb_mips_multicycle_control;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mips_multicycle_control_if #(.CNT_W(CNT_W)) bus ();
    mips_multicycle_control #(.MEM_HANDSHAKE(1), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;
    bit ill_pend = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected control word for a state, from the per-state output table.
    function automatic logic [13:0] exp_out(input int st, input logic rdy, input logic z);
        logic [1:0] aop = 2'b00, sb = 2'b00, ps = 2'b00;
        logic sa = 0, pe = 0, iod = 0, irw = 0, mw = 0, rd = 0, m2r = 0, rw = 0;
        case (st)
            0:  begin sb = 2'b01; irw = rdy; pe = rdy; end
            1:  sb = 2'b11;
            2:  begin sa = 1; sb = 2'b10; end
            3:  iod = 1;
            4:  begin m2r = 1; rw = 1; end
            5:  begin iod = 1; mw = 1; end
            6:  begin sa = 1; aop = 2'b10; end
            7:  begin rd = 1; rw = 1; end
            8:  begin sa = 1; aop = 2'b01; ps = 2'b01; pe = z; end
            9:  begin sa = 1; sb = 2'b10; end
            10: rw = 1;
            11: begin ps = 2'b10; pe = 1; end
            default: ;
        endcase
        return {aop, sa, sb, ps, pe, iod, irw, mw, rd, m2r, rw};
    endfunction

    function automatic logic [13:0] dut_out();
        return {bus.alu_op, bus.alu_src_a, bus.alu_src_b, bus.pc_src, bus.pc_en, bus.i_or_d,
                bus.ir_write, bus.mem_write, bus.reg_dst, bus.mem_to_reg, bus.reg_write};
    endfunction

    // zsel < 0: zero random every cycle; abort_at >= 0: reset asserted on that cycle index.
    task automatic run_instr(input logic [5:0] op, input int fst, input int mst,
                             input int zsel, input int abort_at);
        int  seq[$];
        bit  rdy[$];
        bit  legal;
        logic z;
        legal = 1'b1;
        repeat (fst) begin seq.push_back(0); rdy.push_back(1'b0); end
        seq.push_back(0); rdy.push_back(1'b1);
        seq.push_back(1); rdy.push_back(1'($urandom_range(0, 1)));
        case (op)
            6'b100011: begin
                seq.push_back(2); rdy.push_back(1'($urandom_range(0, 1)));
                repeat (mst) begin seq.push_back(3); rdy.push_back(1'b0); end
                seq.push_back(3); rdy.push_back(1'b1);
                seq.push_back(4); rdy.push_back(1'($urandom_range(0, 1)));
            end
            6'b101011: begin
                seq.push_back(2); rdy.push_back(1'($urandom_range(0, 1)));
                repeat (mst) begin seq.push_back(5); rdy.push_back(1'b0); end
                seq.push_back(5); rdy.push_back(1'b1);
            end
            6'b000000: begin
                seq.push_back(6); rdy.push_back(1'($urandom_range(0, 1)));
                seq.push_back(7); rdy.push_back(1'($urandom_range(0, 1)));
            end
            6'b000100: begin seq.push_back(8); rdy.push_back(1'($urandom_range(0, 1))); end
            6'b001000: begin
                seq.push_back(9);  rdy.push_back(1'($urandom_range(0, 1)));
                seq.push_back(10); rdy.push_back(1'($urandom_range(0, 1)));
            end
            6'b000010: begin seq.push_back(11); rdy.push_back(1'($urandom_range(0, 1))); end
            default: legal = 1'b0;
        endcase
        for (int i = 0; i < seq.size(); i++) begin
            @(negedge clk);
            z = (zsel < 0) ? 1'($urandom_range(0, 1)) : 1'(zsel);
            bus.opcode    = op;
            bus.mem_ready = rdy[i];
            bus.zero      = z;
            if (i == abort_at) begin
                rst = 1'b1;
                #1;
                chk("abort_enables", 32'({bus.pc_en, bus.ir_write, bus.mem_write, bus.reg_write}), 32'd0);
                @(posedge clk);
                #1;
                chk("abort_state", 32'(bus.state), 32'd0);
                chk("abort_count", 32'(bus.instr_count), 32'd0);
                chk("abort_illegal", 32'(bus.illegal_op), 32'd0);
                rst = 1'b0;
                exp_cnt = 0;
                ill_pend = 1'b0;
                return;
            end
            #1;
            chk($sformatf("state op=%b cyc=%0d", op, i), 32'(bus.state), 32'(seq[i]));
            chk($sformatf("outs st=%0d", seq[i]), 32'(dut_out()), 32'(exp_out(seq[i], rdy[i], z)));
            chk($sformatf("count op=%b cyc=%0d", op, i), 32'(bus.instr_count), 32'(exp_cnt));
            chk($sformatf("illegal op=%b cyc=%0d", op, i), 32'(bus.illegal_op),
                32'((i == 0) ? ill_pend : 1'b0));
        end
        if (legal) exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
        ill_pend = !legal;
    endtask

    initial begin
        logic [5:0] ops [6];
        logic [5:0] op;
        ops[0] = 6'b100011; ops[1] = 6'b101011; ops[2] = 6'b000000;
        ops[3] = 6'b000100; ops[4] = 6'b001000; ops[5] = 6'b000010;

        rst = 1'b1;
        bus.mem_ready = 1'b1;
        bus.opcode    = 6'b000000;
        bus.zero      = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("reset_state", 32'(bus.state), 32'd0);
            chk("reset_enables", 32'({bus.pc_en, bus.ir_write, bus.mem_write, bus.reg_write}), 32'd0);
            chk("reset_count", 32'(bus.instr_count), 32'd0);
            chk("reset_illegal", 32'(bus.illegal_op), 32'd0);
        end
        rst = 1'b0;

        run_instr(6'b000000, 0, 0, -1, -1);
        run_instr(6'b100011, 0, 3, -1, -1);
        run_instr(6'b000100, 0, 0, 1, -1);
        run_instr(6'b000100, 0, 0, 0, -1);
        run_instr(6'b111111, 0, 0, -1, -1);
        run_instr(6'b001000, 2, 0, -1, -1);
        run_instr(6'b101011, 0, 2, -1, 4);
        run_instr(6'b000010, 0, 0, -1, -1);

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 4) == 0) op = 6'($urandom_range(0, 63));
            else op = ops[$urandom_range(0, 5)];
            run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), -1, -1);
        end
        run_instr(6'b000000, 0, 0, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
